// File: rtl/axi4_slave_reg_bridge_pkg.sv
// AXI4 slave register bridge: shared types.
// Burst/response encodings and the single supported beat size.
package axi4_slave_reg_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] SIZE_4B = 3'b010;

  // DECERR outranks SLVERR outranks OKAY
  function automatic resp_t resp_worst(resp_t a, resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_slave_reg_bridge_if.sv
// AXI4 slave bundle (AW/W/B/AR/R) without IDs.
// master drives requests, slave returns readies/responses.
interface axi4_slave_reg_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic                    awlock;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic                    arlock;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst,
    output awcache, awlock, awprot, awqos,
    output awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst,
    output arcache, arlock, arprot, arqos,
    output arregion, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst,
    input  awcache, awlock, awprot, awqos,
    input  awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst,
    input  arcache, arlock, arprot, arqos,
    input  arregion, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_slave_reg_bridge_addr_gen.sv
// Burst walker: register index, beat count and per-beat response.
// Shared by reads and writes since only one burst is ever live.
module axi_burst_addr_gen
  import axi4_slave_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  output logic [REG_AW-1:0]     idx,
  output resp_t                 resp,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] word;
  logic [7:0]            len_q;
  logic [7:0]            cnt;
  logic                  incr;
  logic                  berr;
  logic                  herr;
  logic                  carry;

  assign word = addr >> 2;
  assign last = (cnt == len_q);

  // latch burst on address accept, step index/count per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      len_q <= '0;
      cnt   <= '0;
      incr  <= 1'b0;
      berr  <= 1'b0;
      herr  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      idx   <= word[REG_AW-1:0];
      len_q <= len;
      cnt   <= '0;
      incr  <= (burst == BURST_INCR);
      berr  <= (size != SIZE_4B) | burst[1];
      herr  <= |word[ADDR_WIDTH-1:REG_AW];
      carry <= 1'b0;
    end else if (adv) begin
      cnt <= cnt + 8'd1;
      if (incr) begin
        idx   <= idx + REG_AW'(1);
        carry <= carry | (&idx);
      end
    end
  end

  // decode errors win over whole-burst errors
  always_comb begin
    resp = RESP_OKAY;
    if (herr | carry) begin
      resp = RESP_DECERR;
    end else if (berr) begin
      resp = RESP_SLVERR;
    end
  end

endmodule

// File: rtl/axi4_slave_reg_bridge.sv
// AXI4 slave to register-file bridge.
// Splits each burst into single-beat register strobes, one burst at a time.
module axi4_slave_reg_bridge
  import axi4_slave_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  axi4_slave_reg_bridge_if.slave  s_axi,
  output logic                    reg_wr_en,
  output logic [REG_AW-1:0]       reg_wr_addr,
  output logic [DATA_WIDTH-1:0]   reg_wr_data,
  output logic [DATA_WIDTH/8-1:0] reg_wr_strb,
  output logic                    reg_rd_en,
  output logic [REG_AW-1:0]       reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]   reg_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_DATA
  } state_t;

  state_t                state;
  logic                  last_wr;
  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;
  logic                  rlast_q;

  logic [REG_AW-1:0]     idx;
  resp_t                 beat_resp;
  resp_t                 w_resp;
  logic                  last;
  logic                  beat_ok;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  aw_fire;
  logic                  ar_fire;
  logic                  w_fire;
  logic                  r_fire;
  logic                  load;
  logic                  adv;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [7:0]            ld_len;
  logic [1:0]            ld_burst;
  logic [2:0]            ld_size;

  assign grant_wr = s_axi.awvalid
                  & (~s_axi.arvalid | ~last_wr);
  assign grant_rd = s_axi.arvalid & ~grant_wr;

  assign s_axi.awready = (state == S_IDLE) & grant_wr;
  assign s_axi.arready = (state == S_IDLE) & grant_rd;
  assign s_axi.wready  = (state == S_WR_DATA);

  assign aw_fire = s_axi.awvalid & s_axi.awready;
  assign ar_fire = s_axi.arvalid & s_axi.arready;
  assign w_fire  = s_axi.wvalid & s_axi.wready;
  assign r_fire  = rvalid_q & s_axi.rready;

  assign load     = aw_fire | ar_fire;
  assign adv      = w_fire | (r_fire & ~rlast_q);
  assign ld_addr  = aw_fire ? s_axi.awaddr  : s_axi.araddr;
  assign ld_len   = aw_fire ? s_axi.awlen   : s_axi.arlen;
  assign ld_burst = aw_fire ? s_axi.awburst : s_axi.arburst;
  assign ld_size  = aw_fire ? s_axi.awsize  : s_axi.arsize;

  assign beat_ok = (beat_resp == RESP_OKAY);
  assign w_resp  = (s_axi.wlast != last)
                 ? resp_worst(beat_resp, RESP_SLVERR)
                 : beat_resp;

  assign reg_wr_en   = w_fire & beat_ok;
  assign reg_wr_addr = idx;
  assign reg_wr_data = s_axi.wdata;
  assign reg_wr_strb = s_axi.wstrb;
  assign reg_rd_en   = (state == S_RD_ISSUE) & beat_ok;
  assign reg_rd_addr = idx;

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rlast  = rlast_q;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_AW     (REG_AW)
  ) u_addr_gen (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .load  (load),
    .adv   (adv),
    .addr  (ld_addr),
    .len   (ld_len),
    .burst (ld_burst),
    .size  (ld_size),
    .idx   (idx),
    .resp  (beat_resp),
    .last  (last)
  );

  // transaction FSM with registered B/R channel outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state    <= S_IDLE;
      last_wr  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (aw_fire) begin
            bresp_q <= RESP_OKAY;
            state   <= S_WR_DATA;
          end else if (ar_fire) begin
            state <= S_RD_ISSUE;
          end
        end
        S_WR_DATA: begin
          if (w_fire) begin
            bresp_q <= resp_worst(bresp_q, w_resp);
            if (last) begin
              bvalid_q <= 1'b1;
              state    <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            last_wr  <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rdata_q  <= beat_ok ? reg_rd_data : '0;
          rresp_q  <= beat_resp;
          rlast_q  <= last;
          rvalid_q <= 1'b1;
          state    <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              last_wr <= 1'b0;
              state   <= S_IDLE;
            end else begin
              state <= S_RD_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_reg_bridge.sv
// Scoreboard bench for axi4_slave_reg_bridge.
// Reference model computes strobes/responses from burst rules directly.
module tb_axi4_slave_reg_bridge;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RAW  = 4;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_slave_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s();

  logic           reg_wr_en;
  logic [RAW-1:0] reg_wr_addr;
  logic [DW-1:0]  reg_wr_data;
  logic [3:0]     reg_wr_strb;
  logic           reg_rd_en;
  logic [RAW-1:0] reg_rd_addr;
  logic [DW-1:0]  reg_rd_data;

  axi4_slave_reg_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .REG_AW     (RAW)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (s),
    .reg_wr_en     (reg_wr_en),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_strb   (reg_wr_strb),
    .reg_rd_en     (reg_rd_en),
    .reg_rd_addr   (reg_rd_addr),
    .reg_rd_data   (reg_rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pmem [NREG];
  logic [31:0] mmem [NREG];
  logic [39:0] q_wr [$];
  logic [3:0]  q_rd [$];
  logic [1:0]  q_b  [$];
  logic [34:0] q_r  [$];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  bit          wflip [256];

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // peripheral register file with one-cycle read latency
  always @(posedge clk) begin
    if (reg_wr_en)
      for (int i = 0; i < 4; i++)
        if (reg_wr_strb[i])
          pmem[reg_wr_addr][8*i +: 8] <= reg_wr_data[8*i +: 8];
    if (reg_rd_en)
      reg_rd_data <= pmem[reg_rd_addr];
  end

  // monitor: compare every DUT output event with the scoreboard
  logic        pb_stall = 1'b0;
  logic        pr_stall = 1'b0;
  logic [1:0]  pb_resp;
  logic [34:0] pr_pay;
  always @(negedge clk) begin
    if (!rst_n) begin
      pb_stall = 1'b0;
      pr_stall = 1'b0;
    end else begin
      if (pb_stall)
        cmp("b_hold", {s.bvalid, s.bresp}, {1'b1, pb_resp});
      if (pr_stall)
        cmp("r_hold", {s.rvalid, s.rdata, s.rresp, s.rlast}, {1'b1, pr_pay});
      if (reg_wr_en) begin
        if (q_wr.size() == 0) fail_now("wr_strobe_extra");
        else cmp("wr_strobe", {reg_wr_addr, reg_wr_data, reg_wr_strb}, q_wr.pop_front());
      end
      if (reg_rd_en) begin
        if (q_rd.size() == 0) fail_now("rd_strobe_extra");
        else cmp("rd_strobe", reg_rd_addr, q_rd.pop_front());
      end
      if (s.bvalid && s.bready) begin
        if (q_b.size() == 0) fail_now("b_extra");
        else cmp("bresp", s.bresp, q_b.pop_front());
      end
      if (s.rvalid && s.rready) begin
        if (q_r.size() == 0) fail_now("r_extra");
        else cmp("r_beat", {s.rdata, s.rresp, s.rlast}, q_r.pop_front());
      end
      pb_stall = s.bvalid && !s.bready;
      pb_resp  = s.bresp;
      pr_stall = s.rvalid && !s.rready;
      pr_pay   = {s.rdata, s.rresp, s.rlast};
    end
  end

  // reference model: per-beat response from the burst rules
  function automatic logic [1:0] m_resp(logic [31:0] a, int b, logic [1:0] bu, logic [2:0] sz);
    int  base = int'((a >> 2) % NREG);
    bit  de = ((a >> (RAW + 2)) != 0) || (bu == 2'b01 && base + b > NREG - 1);
    bit  be = (sz != 3'b010) || (bu >= 2'b10);
    return de ? 2'b11 : (be ? 2'b10 : 2'b00);
  endfunction

  function automatic logic [3:0] m_idx(logic [31:0] a, int b, logic [1:0] bu);
    int base = int'((a >> 2) % NREG);
    return 4'((base + ((bu == 2'b01) ? b : 0)) % NREG);
  endfunction

  function automatic logic [1:0] worst(logic [1:0] x, logic [1:0] y);
    return (x > y) ? x : y;
  endfunction

  task automatic exp_write(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz);
    logic [1:0] br = 2'b00;
    for (int b = 0; b <= len; b++) begin
      logic [1:0] r = m_resp(a, b, bu, sz);
      if (r == 2'b00) begin
        logic [3:0] ix = m_idx(a, b, bu);
        q_wr.push_back({ix, wd[b], ws[b]});
        for (int k = 0; k < 4; k++)
          if (ws[b][k]) mmem[ix][8*k +: 8] = wd[b][8*k +: 8];
      end
      if (wflip[b]) r = worst(r, 2'b10);
      br = worst(br, r);
    end
    q_b.push_back(br);
  endtask

  task automatic exp_read(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz);
    for (int b = 0; b <= len; b++) begin
      logic [1:0]  r = m_resp(a, b, bu, sz);
      logic [31:0] d = 32'h0;
      if (r == 2'b00) begin
        logic [3:0] ix = m_idx(a, b, bu);
        q_rd.push_back(ix);
        d = mmem[ix];
      end
      q_r.push_back({d, r, (b == len) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic fill(int len, int flip);
    for (int b = 0; b <= len; b++) begin
      wd[b]    = $urandom;
      ws[b]    = 4'($urandom_range(0, 15));
      wflip[b] = (b == flip);
    end
  endtask

  task automatic drive_aw(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz);
    s.awaddr = a; s.awlen = 8'(len); s.awburst = bu; s.awsize = sz;
    s.awvalid = 1'b1;
  endtask

  task automatic drive_ar(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz);
    s.araddr = a; s.arlen = 8'(len); s.arburst = bu; s.arsize = sz;
    s.arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s.awready) begin
        @(posedge clk); #1;
        s.awvalid = 1'b0;
        return;
      end
    end
    fail_now("aw_timeout");
    s.awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s.arready) begin
        @(posedge clk); #1;
        s.arvalid = 1'b0;
        return;
      end
    end
    fail_now("ar_timeout");
    s.arvalid = 1'b0;
  endtask

  task automatic send_w(int len, bit gaps);
    for (int b = 0; b <= len; b++) begin
      bit ok = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      s.wvalid = 1'b1;
      s.wdata  = wd[b];
      s.wstrb  = ws[b];
      s.wlast  = (b == len) ^ wflip[b];
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        ok = s.wready;
      end
      if (!ok) begin
        fail_now("w_timeout");
        s.wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s.wvalid = 1'b0;
      s.wlast  = 1'b0;
    end
  endtask

  task automatic recv_b(int delay);
    bit ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = s.bvalid;
    end
    if (!ok) begin
      fail_now("b_timeout");
      return;
    end
    @(posedge clk); #1;
    repeat (delay) begin
      @(posedge clk); #1;
    end
    s.bready = 1'b1;
    @(posedge clk); #1;
    s.bready = 1'b0;
  endtask

  task automatic recv_r(int nbeats, int dmax);
    for (int b = 0; b < nbeats; b++) begin
      bit ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        ok = s.rvalid;
      end
      if (!ok) begin
        fail_now("r_timeout");
        return;
      end
      @(posedge clk); #1;
      repeat ($urandom_range(0, dmax)) begin
        @(posedge clk); #1;
      end
      s.rready = 1'b1;
      @(posedge clk); #1;
      s.rready = 1'b0;
    end
  endtask

  task automatic do_write(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz, int bd);
    exp_write(a, len, bu, sz);
    drive_aw(a, len, bu, sz);
    wait_aw();
    send_w(len, 1'b1);
    recv_b(bd);
  endtask

  task automatic do_read(logic [31:0] a, int len, logic [1:0] bu, logic [2:0] sz, int dmax);
    exp_read(a, len, bu, sz);
    drive_ar(a, len, bu, sz);
    wait_ar();
    recv_r(len + 1, dmax);
  endtask

  initial begin
    s.awaddr = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0;
    s.awcache = '0; s.awlock = 1'b0; s.awprot = '0; s.awqos = '0;
    s.awregion = '0; s.awvalid = 1'b0;
    s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0; s.wvalid = 1'b0;
    s.bready = 1'b0;
    s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0;
    s.arcache = '0; s.arlock = 1'b0; s.arprot = '0; s.arqos = '0;
    s.arregion = '0; s.arvalid = 1'b0;
    s.rready = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pmem[i] = $urandom;
      mmem[i] = pmem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_outputs",
        {s.awready, s.arready, s.wready, s.bvalid, s.bresp,
         s.rvalid, s.rresp, s.rlast, reg_wr_en, reg_rd_en},
        '0);
    cmp("reset_rdata", s.rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // simultaneous AW/AR from reset: write first, then read
    fill(0, -1);
    exp_write(32'h10, 0, 2'b01, 3'b010);
    drive_aw(32'h10, 0, 2'b01, 3'b010);
    drive_ar(32'h14, 0, 2'b01, 3'b010);
    @(negedge clk);
    cmp("grant_first_wr", {s.awready, s.arready}, 2'b10);
    @(posedge clk); #1;
    s.awvalid = 1'b0;
    send_w(0, 1'b0);
    recv_b(0);
    exp_read(32'h14, 0, 2'b01, 3'b010);
    fill(0, -1);
    exp_write(32'h18, 0, 2'b01, 3'b010);
    drive_aw(32'h18, 0, 2'b01, 3'b010);
    @(negedge clk);
    cmp("grant_next_rd", {s.awready, s.arready}, 2'b01);
    @(posedge clk); #1;
    s.arvalid = 1'b0;
    recv_r(1, 0);
    wait_aw();
    send_w(0, 1'b0);
    recv_b(0);

    // INCR write of four beats at 0x8
    fill(3, -1);
    for (int b = 0; b < 4; b++) begin
      wd[b] = 32'hA0A0_0000 + 32'(b);
      ws[b] = 4'hF;
    end
    do_write(32'h8, 3, 2'b01, 3'b010, 0);

    // INCR read crossing the top of register space
    do_read(32'h38, 3, 2'b01, 3'b010, 1);

    // FIXED write, then a bad-size write
    fill(2, -1);
    do_write(32'h4, 2, 2'b00, 3'b010, 0);
    fill(1, -1);
    do_write(32'h4, 1, 2'b01, 3'b001, 0);

    // early wlast with long B stall, then stalled reads
    fill(3, 1);
    do_write(32'h20, 3, 2'b01, 3'b010, 10);
    do_read(32'h20, 3, 2'b01, 3'b010, 3);

    // reset during beat 2 of an 8-beat read
    exp_read(32'h0, 7, 2'b01, 3'b010);
    drive_ar(32'h0, 7, 2'b01, 3'b010);
    wait_ar();
    recv_r(2, 0);
    for (int t = 0; t < 20 && !s.rvalid; t++) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    cmp("abort_rvalid", {s.rvalid, s.bvalid, reg_rd_en}, 3'b000);
    q_r.delete();
    q_rd.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'h0, 1, 2'b01, 3'b010, 0);

    // randomized mix of reads and writes
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          len;
      int          r;
      logic [1:0]  bu;
      logic [2:0]  sz;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'($urandom_range(1, 255)) << 6);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                        : int'($urandom_range(0, 5));
      r  = int'($urandom_range(0, 9));
      bu = (r < 5) ? 2'b01 : ((r < 8) ? 2'b00 : 2'(r - 6));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      if ($urandom_range(0, 1) == 1) begin
        fill(len, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1);
        do_write(a, len, bu, sz, int'($urandom_range(0, 2)));
      end else begin
        do_read(a, len, bu, sz, 2);
      end
    end

    // 256-beat FIXED write and read
    fill(255, -1);
    do_write(32'hC, 255, 2'b00, 3'b010, 0);
    do_read(32'hC, 255, 2'b00, 3'b010, 0);

    repeat (5) @(posedge clk);
    #1;
    cmp("queues_empty",
        q_wr.size() + q_rd.size() + q_b.size() + q_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
